// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush/freeze controller: decodes hazard-unit events into register enables/clears and ALU forwarding selects.
// Optional performance counters are built only when HAZ_PERF_CNT_EN is defined.
module pipeline_stall_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             loaduse,
  input  logic             branch,
  input  logic             e_rs,
  input  logic             m_rs,
  input  logic             e_rt,
  input  logic             m_rt,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_clr,
  output logic             idex_en,
  output logic             idex_clr,
  output logic             exmem_en,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] busy_cnt
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LU_BUBBLE,
    ST_FLUSH,
    ST_MEM_WAIT
  } state_t;

  localparam int         RELOAD_I    = FLUSH_CYCLES - 1;
  localparam logic [3:0] FCNT_RELOAD = RELOAD_I[3:0];

  state_t     state_reg, state_next, eff_state;
  logic [3:0] fcnt_reg, fcnt_next;
  logic       ret_reg, ret_next;  // 0: resume RUN, 1: resume FLUSH
  logic [1:0] fwd_a_reg, fwd_b_reg;
  logic [1:0] fwd_a_now, fwd_b_now;
  logic       ev_stall, ev_flush, ev_busy;

  // Leaving MEM_WAIT is decoded as the resumed state in the same cycle.
  always_comb begin
    eff_state = state_reg;
    if (state_reg == ST_MEM_WAIT && !mem_busy) begin
      eff_state = ret_reg ? ST_FLUSH : ST_RUN;
    end
  end

  always_comb begin
    state_next = state_reg;
    fcnt_next  = fcnt_reg;
    ret_next   = ret_reg;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_clr   = 1'b0;
    idex_en    = 1'b1;
    idex_clr   = 1'b0;
    exmem_en   = 1'b1;
    ev_stall   = 1'b0;
    ev_flush   = 1'b0;
    ev_busy    = 1'b0;

    case (eff_state)
      ST_MEM_WAIT: begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        ev_busy    = 1'b1;
        state_next = ST_MEM_WAIT;
      end

      ST_FLUSH: begin
        if (mem_busy) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_en    = 1'b0;
          exmem_en   = 1'b0;
          ev_busy    = 1'b1;
          ret_next   = 1'b1;
          state_next = ST_MEM_WAIT;
        end else begin
          ifid_clr = 1'b1;
          idex_clr = 1'b1;
          ev_flush = 1'b1;
          if (branch) begin
            fcnt_next  = FCNT_RELOAD;
            state_next = ST_FLUSH;
          end else if (fcnt_reg <= 4'd1) begin
            fcnt_next  = 4'd0;
            state_next = ST_RUN;
          end else begin
            fcnt_next  = fcnt_reg - 4'd1;
            state_next = ST_FLUSH;
          end
        end
      end

      default: begin  // RUN and LU_BUBBLE share event handling
        if (mem_busy) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_en    = 1'b0;
          exmem_en   = 1'b0;
          ev_busy    = 1'b1;
          ret_next   = 1'b0;
          state_next = ST_MEM_WAIT;
        end else if (branch) begin
          ifid_clr = 1'b1;
          idex_clr = 1'b1;
          ev_flush = 1'b1;
          if (FLUSH_CYCLES == 1) begin
            state_next = ST_RUN;
          end else begin
            fcnt_next  = FCNT_RELOAD;
            state_next = ST_FLUSH;
          end
        end else if (loaduse && eff_state == ST_RUN) begin
          // Only one bubble per hazard: LU_BUBBLE ignores a still-high loaduse.
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_clr   = 1'b1;
          ev_stall   = 1'b1;
          state_next = ST_LU_BUBBLE;
        end else begin
          state_next = ST_RUN;
        end
      end
    endcase

    if (rst) begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      ifid_clr = 1'b0;
      idex_en  = 1'b1;
      idex_clr = 1'b0;
      exmem_en = 1'b1;
      ev_stall = 1'b0;
      ev_flush = 1'b0;
      ev_busy  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_RUN;
      fcnt_reg  <= 4'd0;
      ret_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      fcnt_reg  <= fcnt_next;
      ret_reg   <= ret_next;
    end
  end

  // EX beats MEM: the younger result is the correct one to forward.
  assign fwd_a_now = e_rs ? 2'b01 : (m_rs ? 2'b10 : 2'b00);
  assign fwd_b_now = e_rt ? 2'b01 : (m_rt ? 2'b10 : 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a_reg <= 2'b00;
      fwd_b_reg <= 2'b00;
    end else if (exmem_en) begin
      fwd_a_reg <= fwd_a_now;
      fwd_b_reg <= fwd_b_now;
    end
  end

  // A frozen EX stage keeps the selects it captured before the freeze.
  assign fwd_a_sel = rst ? 2'b00 : (exmem_en ? fwd_a_now : fwd_a_reg);
  assign fwd_b_sel = rst ? 2'b00 : (exmem_en ? fwd_b_now : fwd_b_reg);

`ifdef HAZ_PERF_CNT_EN
  logic [2:0]            cnt_inc;
  logic [2:0][CNT_W-1:0] cnt_reg;
  logic [2:0][CNT_W-1:0] cnt_next;

  assign cnt_inc = {ev_busy, ev_flush, ev_stall};

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    assign cnt_next[gi] = (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}}))
                          ? cnt_reg[gi] + {{(CNT_W-1){1'b0}}, 1'b1}
                          : cnt_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign stall_cnt = cnt_reg[0];
  assign flush_cnt = cnt_reg[1];
  assign busy_cnt  = cnt_reg[2];
`else
  logic unused_ev;
  assign unused_ev = ^{ev_stall, ev_flush, ev_busy};
  assign stall_cnt = '0;
  assign flush_cnt = '0;
  assign busy_cnt  = '0;
`endif

endmodule
